coincidence_rate_counter: RTL and testbench

//  Consumes the stretched pulse_out lines of N_CH monostables (one per detector channel).

---
 rtl/coincidence_rate_counter.sv | 147 ++++++++++++++
 tb/tb_coincidence_rate_counter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coincidence_rate_counter.sv
// Gated rate counter for N_CH monostable outputs: per-channel rising-edge counts plus a
// masked multiplicity coincidence, latched at the end of each back-to-back gate window.
module coincidence_rate_counter #(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 32,
   parameter int GATE_W = 30
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_CH-1:0]             pulse_in,
   input  logic [N_CH-1:0]             ch_mask,
   input  logic [$clog2(N_CH+1)-1:0]   min_mult,
   input  logic [GATE_W-1:0]           gate_len,
   input  logic                        enable,
   output logic                        coinc_out,
   output logic [N_CH*CNT_W-1:0]       ch_count_out,
   output logic [CNT_W-1:0]            coinc_count_out,
   output logic                        counts_valid
);

   localparam int MULT_W = $clog2(N_CH+1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [0:0]                       state_q, state_d;
   logic [GATE_W-1:0]                timer_q, timer_d;
   logic [N_CH-1:0]                  pulse_prev_q, pulse_prev_d;
   logic                             cond_prev_q, cond_prev_d;
   logic                             coinc_q, coinc_d;
   logic                             valid_q, valid_d;
   logic [N_CH-1:0][CNT_W-1:0]       live_ch_q, live_ch_d;
   logic [CNT_W-1:0]                 live_coinc_q, live_coinc_d;
   logic [N_CH-1:0][CNT_W-1:0]       lat_ch_q, lat_ch_d;
   logic [CNT_W-1:0]                 lat_coinc_q, lat_coinc_d;

   logic [MULT_W-1:0]                mult;
   logic                             cond;
   logic [N_CH-1:0]                  ch_edge;
   logic                             coinc_event;
   logic [GATE_W-1:0]                gate_load;
   logic [N_CH-1:0][CNT_W-1:0]       ch_sum;
   logic [CNT_W-1:0]                 coinc_sum;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   always_comb begin
      mult = '0;
      for (int i = 0; i < N_CH; i++) begin
         mult = mult + MULT_W'(pulse_in[i] & ch_mask[i]);
      end
   end

   assign cond        = (min_mult != '0) && (mult >= min_mult);
   assign ch_edge     = pulse_in & ~pulse_prev_q;
   assign coinc_event = cond & ~cond_prev_q;
   assign gate_load   = (gate_len == '0) ? GATE_W'(1) : gate_len;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_sum[i] = sat_inc(live_ch_q[i], ch_edge[i]);
      end
      coinc_sum = sat_inc(live_coinc_q, coinc_event);
   end

   // The last window cycle latches live+current increments so an edge there is not lost.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      pulse_prev_d = pulse_in;
      cond_prev_d  = cond;
      coinc_d      = cond;
      valid_d      = 1'b0;
      live_ch_d    = live_ch_q;
      live_coinc_d = live_coinc_q;
      lat_ch_d     = lat_ch_q;
      lat_coinc_d  = lat_coinc_q;
      case (state_q)
         S_IDLE: begin
            live_ch_d    = '0;
            live_coinc_d = '0;
            if (enable) begin
               state_d = S_RUN;
               timer_d = gate_load;
            end
         end
         S_RUN: begin
            if (timer_q == GATE_W'(1)) begin
               lat_ch_d     = ch_sum;
               lat_coinc_d  = coinc_sum;
               valid_d      = 1'b1;
               live_ch_d    = '0;
               live_coinc_d = '0;
               if (enable) begin
                  timer_d = gate_load;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (!enable) begin
               state_d      = S_IDLE;
               live_ch_d    = '0;
               live_coinc_d = '0;
            end else begin
               live_ch_d    = ch_sum;
               live_coinc_d = coinc_sum;
               timer_d      = timer_q - GATE_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Previous-sample registers reset high so lines already active at release are not edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         pulse_prev_q <= '1;
         cond_prev_q  <= 1'b1;
         coinc_q      <= 1'b0;
         valid_q      <= 1'b0;
         live_ch_q    <= '0;
         live_coinc_q <= '0;
         lat_ch_q     <= '0;
         lat_coinc_q  <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         pulse_prev_q <= pulse_prev_d;
         cond_prev_q  <= cond_prev_d;
         coinc_q      <= coinc_d;
         valid_q      <= valid_d;
         live_ch_q    <= live_ch_d;
         live_coinc_q <= live_coinc_d;
         lat_ch_q     <= lat_ch_d;
         lat_coinc_q  <= lat_coinc_d;
      end
   end

   assign coinc_out       = coinc_q;
   assign counts_valid    = valid_q;
   assign ch_count_out    = lat_ch_q;
   assign coinc_count_out = lat_coinc_q;

endmodule

// File: tb/tb_coincidence_rate_counter.sv
// Directed bench for coincidence_rate_counter: a window-level reference model checked every
// cycle against a full-width instance and a 4-bit saturating instance, plus literal checks.
module tb_coincidence_rate_counter;

   localparam int N_CH   = 4;
   localparam int CNT_W  = 32;
   localparam int SAT_W  = 4;
   localparam int GATE_W = 30;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [3:0]        pulse_in;
   logic [3:0]        ch_mask;
   logic [2:0]        min_mult;
   logic [GATE_W-1:0] gate_len;
   logic              enable;

   logic              coinc_out, counts_valid;
   logic [127:0]      ch_count_out;
   logic [31:0]       coinc_count_out;
   logic              sat_coinc_out, sat_counts_valid;
   logic [15:0]       sat_ch_count_out;
   logic [3:0]        sat_coinc_count_out;

   int checks = 0;
   int errors = 0;

   coincidence_rate_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .ch_mask(ch_mask),
      .min_mult(min_mult), .gate_len(gate_len), .enable(enable),
      .coinc_out(coinc_out), .ch_count_out(ch_count_out),
      .coinc_count_out(coinc_count_out), .counts_valid(counts_valid)
   );

   coincidence_rate_counter #(.N_CH(N_CH), .CNT_W(SAT_W), .GATE_W(GATE_W)) dut_sat (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .ch_mask(ch_mask),
      .min_mult(min_mult), .gate_len(gate_len), .enable(enable),
      .coinc_out(sat_coinc_out), .ch_count_out(sat_ch_count_out),
      .coinc_count_out(sat_coinc_count_out), .counts_valid(sat_counts_valid)
   );

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic longint satv(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Reference model: unbounded window totals, saturation applied only when compared.
   bit         m_live = 1'b0;
   bit         m_run;
   int         m_rem;
   longint     m_live_ch [4];
   longint     m_live_coinc;
   longint     m_lat_ch [4];
   longint     m_lat_coinc;
   bit         m_valid, m_coinc;
   logic [3:0] m_prev_pulse;
   bit         m_prev_cond;

   always @(posedge clk) begin : model
      bit         cond;
      bit         ev;
      logic [3:0] edges;
      if (reset) begin
         m_live = 1'b1;
         m_run = 1'b0;
         m_rem = 0;
         for (int i = 0; i < 4; i++) begin
            m_live_ch[i] = 0;
            m_lat_ch[i] = 0;
         end
         m_live_coinc = 0;
         m_lat_coinc = 0;
         m_valid = 1'b0;
         m_coinc = 1'b0;
         m_prev_pulse = 4'hF;
         m_prev_cond = 1'b1;
      end else if (m_live) begin
         cond = (min_mult != 0) && ($countones(pulse_in & ch_mask) >= int'(min_mult));
         edges = pulse_in & ~m_prev_pulse;
         ev = cond && !m_prev_cond;
         m_coinc = cond;
         m_valid = 1'b0;
         if (!m_run) begin
            if (enable) begin
               m_run = 1'b1;
               m_rem = (gate_len == 0) ? 1 : int'(gate_len);
            end
         end else begin
            for (int i = 0; i < 4; i++) m_live_ch[i] += longint'(edges[i]);
            m_live_coinc += longint'(ev);
            if (m_rem == 1) begin
               for (int i = 0; i < 4; i++) begin
                  m_lat_ch[i] = m_live_ch[i];
                  m_live_ch[i] = 0;
               end
               m_lat_coinc = m_live_coinc;
               m_live_coinc = 0;
               m_valid = 1'b1;
               if (enable) m_rem = (gate_len == 0) ? 1 : int'(gate_len);
               else m_run = 1'b0;
            end else if (!enable) begin
               m_run = 1'b0;
               for (int i = 0; i < 4; i++) m_live_ch[i] = 0;
               m_live_coinc = 0;
            end else begin
               m_rem--;
            end
         end
         m_prev_pulse = pulse_in;
         m_prev_cond = cond;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         checkOutput("coinc_out", coinc_out, m_coinc);
         checkOutput("counts_valid", counts_valid, m_valid);
         checkOutput("coinc_count", coinc_count_out, satv(m_lat_coinc, CNT_W));
         checkOutput("sat_coinc_out", sat_coinc_out, m_coinc);
         checkOutput("sat_counts_valid", sat_counts_valid, m_valid);
         checkOutput("sat_coinc_count", sat_coinc_count_out, satv(m_lat_coinc, SAT_W));
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ch%0d_count", i), ch_count_out[i*CNT_W +: CNT_W],
                        satv(m_lat_ch[i], CNT_W));
            checkOutput($sformatf("sat_ch%0d_count", i), sat_ch_count_out[i*SAT_W +: SAT_W],
                        satv(m_lat_ch[i], SAT_W));
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] p, input logic [3:0] m, input logic [2:0] mm,
                                input int gl, input logic en);
      pulse_in = p;
      ch_mask  = m;
      min_mult = mm;
      gate_len = GATE_W'(gl);
      enable   = en;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitValid(input string name, input int max_cycles, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < max_cycles) begin
         @(negedge clk);
         n++;
         if (counts_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: no counts_valid within %0d cycles, expected one", name, max_cycles);
      end
   endtask

   function automatic longint chOf(input int i);
      return longint'(ch_count_out[i*CNT_W +: CNT_W]);
   endfunction

   initial begin
      int n;
      int vcount;
      reset = 1'b1;
      applyStimulus(4'h0, 4'hF, 3'd0, 100, 1'b0);
      step(3);
      checkOutput("rst_valid", counts_valid, 0);
      checkOutput("rst_ch0", chOf(0), 0);
      checkOutput("rst_coinc_out", coinc_out, 0);
      reset = 1'b0;

      // T1: single pulse on ch0 at window cycle 10 of 100
      enable = 1'b1;
      step(10);
      pulse_in = 4'b0001;
      step(5);
      pulse_in = 4'b0000;
      waitValid("t1_wait", 200, n);
      checkOutput("t1_latency", n, 86);
      checkOutput("t1_ch0", chOf(0), 1);
      checkOutput("t1_ch1", chOf(1), 0);
      checkOutput("t1_coinc", coinc_count_out, 0);
      enable = 1'b0;
      step(3);

      // T2: masked 2-fold coincidence on ch0/ch1
      applyStimulus(4'b0000, 4'b0011, 3'd2, 20, 1'b1);
      step(3);
      pulse_in = 4'b0001;
      step(2);
      pulse_in = 4'b0011;
      checkOutput("t2_coinc_before", coinc_out, 0);
      step(1);
      checkOutput("t2_coinc_after", coinc_out, 1);
      step(3);
      pulse_in = 4'b0010;
      step(2);
      pulse_in = 4'b0000;
      step(2);
      pulse_in = 4'b0110;
      step(1);
      pulse_in = 4'b0000;
      waitValid("t2_wait", 40, n);
      checkOutput("t2_ch0", chOf(0), 1);
      checkOutput("t2_ch1", chOf(1), 2);
      checkOutput("t2_ch2", chOf(2), 1);
      checkOutput("t2_coinc", coinc_count_out, 1);
      enable = 1'b0;
      step(3);

      // T3: edge on last window cycle, strobe spacing, gate_len change and gate_len=0
      applyStimulus(4'b0000, 4'hF, 3'd0, 10, 1'b1);
      step(10);
      pulse_in = 4'b0001;
      step(1);
      checkOutput("t3_valid_last", counts_valid, 1);
      checkOutput("t3_ch0_last", chOf(0), 1);
      waitValid("t3_wait1", 30, n);
      checkOutput("t3_spacing1", n, 10);
      checkOutput("t3_ch0_next", chOf(0), 0);
      gate_len = GATE_W'(5);
      pulse_in = 4'b0000;
      waitValid("t3_wait2", 30, n);
      checkOutput("t3_spacing2", n, 10);
      waitValid("t3_wait3", 30, n);
      checkOutput("t3_spacing3", n, 5);
      gate_len = '0;
      waitValid("t3_wait4", 30, n);
      checkOutput("t3_spacing4", n, 5);
      waitValid("t3_wait5", 30, n);
      checkOutput("t3_spacing_gate0", n, 1);
      enable = 1'b0;
      step(1);
      checkOutput("t3_valid_on_disable", counts_valid, 1);
      step(1);
      checkOutput("t3_valid_idle", counts_valid, 0);

      // T4: abort at window cycle 50 keeps previous latched values
      applyStimulus(4'b0000, 4'hF, 3'd0, 8, 1'b1);
      step(2);
      pulse_in = 4'b1000;
      step(1);
      pulse_in = 4'b0000;
      waitValid("t4_wait_pre", 20, n);
      checkOutput("t4_ch3_pre", chOf(3), 1);
      enable = 1'b0;
      step(2);
      gate_len = GATE_W'(100);
      enable = 1'b1;
      step(20);
      pulse_in = 4'b0010;
      step(2);
      pulse_in = 4'b0000;
      step(28);
      enable = 1'b0;
      vcount = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (counts_valid) vcount++;
      end
      checkOutput("t4_no_valid", vcount, 0);
      checkOutput("t4_ch3_kept", chOf(3), 1);
      checkOutput("t4_ch1_kept", chOf(1), 0);
      gate_len = GATE_W'(10);
      enable = 1'b1;
      step(3);
      pulse_in = 4'b0100;
      step(1);
      pulse_in = 4'b0000;
      waitValid("t4_wait_fresh", 20, n);
      checkOutput("t4_ch2_fresh", chOf(2), 1);
      checkOutput("t4_ch1_fresh", chOf(1), 0);
      checkOutput("t4_ch3_fresh", chOf(3), 0);
      enable = 1'b0;
      step(2);

      // T5: 20 edges on ch2, 4-bit instance saturates at 15
      applyStimulus(4'b0000, 4'hF, 3'd0, 60, 1'b1);
      step(2);
      for (int k = 0; k < 20; k++) begin
         pulse_in = 4'b0100;
         step(1);
         pulse_in = 4'b0000;
         step(1);
      end
      waitValid("t5_wait", 80, n);
      checkOutput("t5_sat_ch2", sat_ch_count_out[11:8], 15);
      checkOutput("t5_ch2", chOf(2), 20);
      enable = 1'b0;
      step(2);

      // T6: lines high through reset release, min_mult=0, then mid-window reset
      pulse_in = 4'hF;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      applyStimulus(4'hF, 4'hF, 3'd0, 10, 1'b1);
      step(1);
      checkOutput("t6_coinc_out", coinc_out, 0);
      waitValid("t6_wait1", 30, n);
      checkOutput("t6_ch0_held", chOf(0), 0);
      checkOutput("t6_ch3_held", chOf(3), 0);
      step(3);
      pulse_in = 4'h0;
      step(2);
      pulse_in = 4'hF;
      waitValid("t6_wait2", 30, n);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("t6_ch%0d_rise", i), chOf(i), 1);
      checkOutput("t6_coinc_count", coinc_count_out, 0);
      step(4);
      reset = 1'b1;
      step(1);
      checkOutput("t6_reset_ch0", chOf(0), 0);
      checkOutput("t6_reset_valid", counts_valid, 0);
      reset = 1'b0;
      enable = 1'b0;
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
